pipe_register: RTL and testbench

PIPE_REGISTER -- requirements
Module: pipe_register

---
 rtl/pipe_register_pkg.sv | 21 ++
 rtl/pipe_stage.sv | 30 +++
 rtl/pipe_register.sv | 80 ++++++++
 tb/tb_pipe_register.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_register_pkg.sv
// Shared constants for the pipe_register slice: default sizing and the
// ceiling-log2 helper used to size the occupancy counter.
package pipe_register_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 2;

    // Bits needed to represent values 0..value-1; callers pass DEPTH+1 for a 0..DEPTH count.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: a data register plus its valid bit.
// clear wins over load so a flush always empties the slot.
module pipe_stage
    import pipe_register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             v
);

    // Data only changes on a real load, so an emptied slot keeps its last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
            v <= 1'b0;
        end else if (clear) begin
            v <= 1'b0;
        end else if (load) begin
            q <= d;
            v <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_register.sv
// Elastic register pipeline with valid/ready handshakes on both sides,
// bubble collapsing, synchronous flush and an occupancy count.
module pipe_register
    import pipe_register_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] clear;
    logic [WIDTH-1:0] data     [DEPTH];
    logic [WIDTH-1:0] stage_in [DEPTH];

    // Ready chain walks from the output back; a stage may move if any slot below it is free or out_ready pulls.
    always_comb begin
        logic room;
        adv  = '0;
        room = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            adv[k] = valid[k] && room;
            room   = room || !valid[k];
        end
    end

    assign in_ready = !flush && (!valid[0] || adv[0]);

    always_comb begin
        load    = '0;
        load[0] = in_valid && in_ready;
        for (int k = 1; k < DEPTH; k++) begin
            load[k] = adv[k-1];
        end
    end

    assign clear = {DEPTH{flush}} | (adv & ~load);

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign stage_in[k] = in_data;
        end else begin : g_body
            assign stage_in[k] = data[k-1];
        end

        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[k]),
            .clear (clear[k]),
            .d     (stage_in[k]),
            .q     (data[k]),
            .v     (valid[k])
        );
    end

    assign out_valid = valid[DEPTH-1];
    assign out_data  = data[DEPTH-1];

    always_comb begin
        count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count = count + CW'(valid[k]);
        end
    end

endmodule

// File: tb/tb_pipe_register.sv
// Directed and randomised checks of pipe_register at DEPTH=2 and DEPTH=4,
// with a scoreboard queue for the random handshake phase.
module tb_pipe_register;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       iv2, ir2, ov2, ordy2, fl2;
    logic [7:0] id2, od2;
    logic [1:0] cnt2;

    logic        iv, ir, ov, ordy, fl;
    logic [15:0] id, od;
    logic [2:0]  cnt;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] sb [$];

    logic [7:0] in_d2   [6] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
    logic       exp_ov2 [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_od2 [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    logic [1:0] exp_cnt2[6] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0};

    logic       exp_ir4 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] exp_cnt4[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic       exp_ov4 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    pipe_register #(.WIDTH(8), .DEPTH(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv2),
        .in_ready  (ir2),
        .in_data   (id2),
        .out_valid (ov2),
        .out_ready (ordy2),
        .out_data  (od2),
        .flush     (fl2),
        .count     (cnt2)
    );

    pipe_register #(.WIDTH(16), .DEPTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv),
        .in_ready  (ir),
        .in_data   (id),
        .out_valid (ov),
        .out_ready (ordy),
        .out_data  (od),
        .flush     (fl),
        .count     (cnt)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r, input logic f);
        iv   = v;
        id   = d;
        ordy = r;
        fl   = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        iv2 = 1'b0; id2 = '0; ordy2 = 1'b0; fl2 = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        checkOutput("rst_ov", ov, 0);
        checkOutput("rst_od", od, 0);
        checkOutput("rst_cnt", cnt, 0);
        checkOutput("rst_ir", ir, 1);
        checkOutput("rst_ov2", ov2, 0);
        checkOutput("rst_cnt2", cnt2, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_ir", ir, 1);

        // DEPTH=2 streaming: two-cycle latency, back-to-back output
        ordy2 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            iv2 = (c < 3);
            id2 = in_d2[c];
            #1;
            checkOutput("stream2_ir", ir2, 1);
            checkOutput("stream2_ov", ov2, exp_ov2[c]);
            if (exp_ov2[c]) checkOutput("stream2_od", od2, exp_od2[c]);
            checkOutput("stream2_cnt", cnt2, exp_cnt2[c]);
            step();
        end
        iv2 = 1'b0;

        // DEPTH=4 fill with out_ready low: four accepted, then back-pressure
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 16'(16'h00A1 + c), 1'b0, 1'b0);
            #1;
            checkOutput("fill_ir", ir, exp_ir4[c]);
            checkOutput("fill_cnt", cnt, exp_cnt4[c]);
            checkOutput("fill_ov", ov, exp_ov4[c]);
            if (exp_ov4[c]) checkOutput("fill_od", od, 16'h00A1);
            step();
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        checkOutput("hold_cnt", cnt, 4);
        checkOutput("hold_ov", ov, 1);
        checkOutput("hold_od", od, 16'h00A1);
        checkOutput("hold_ir", ir, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
            #1;
            checkOutput("drain_ov", ov, 1);
            checkOutput("drain_od", od, 16'(16'h00A1 + i));
            checkOutput("drain_cnt", cnt, 4 - i);
            step();
        end
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        #1;
        checkOutput("drained_ov", ov, 0);
        checkOutput("drained_cnt", cnt, 0);

        // Full pipe, one in and one out per cycle
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'(16'h0B00 + i), 1'b0, 1'b0);
            #1;
            checkOutput("prefill_ir", ir, 1);
            step();
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 16'(16'h0B04 + i), 1'b1, 1'b0);
            #1;
            checkOutput("full_ir", ir, 1);
            checkOutput("full_cnt", cnt, 4);
            checkOutput("full_ov", ov, 1);
            checkOutput("full_od", od, 16'(16'h0B00 + i));
            step();
        end

        // Flush at count=3 while a word is offered
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        #1;
        step();
        applyStimulus(1'b1, 16'hCCCC, 1'b0, 1'b1);
        #1;
        checkOutput("flush_pre_cnt", cnt, 3);
        checkOutput("flush_ir", ir, 0);
        step();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        checkOutput("flush_cnt", cnt, 0);
        checkOutput("flush_ov", ov, 0);
        checkOutput("flush_ir_after", ir, 1);
        step();
        checkOutput("flush_stay_cnt", cnt, 0);

        // Asynchronous reset between edges at count=2
        applyStimulus(1'b1, 16'h00D1, 1'b0, 1'b0);
        #1;
        step();
        applyStimulus(1'b1, 16'h00D2, 1'b0, 1'b0);
        #1;
        step();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        checkOutput("prerst_cnt", cnt, 2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_ov", ov, 0);
        checkOutput("arst_od", od, 0);
        checkOutput("arst_cnt", cnt, 0);
        checkOutput("arst_ir", ir, 1);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h00E1, 1'b1, 1'b0);
        #1;
        checkOutput("lat_ir", ir, 1);
        step();
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int k = 1; k < 4; k++) begin
            #1;
            checkOutput("lat_ov_low", ov, 0);
            checkOutput("lat_cnt", cnt, 1);
            step();
        end
        #1;
        checkOutput("lat_ov", ov, 1);
        checkOutput("lat_od", od, 16'h00E1);
        step();
        checkOutput("lat_done_ov", ov, 0);
        checkOutput("lat_done_cnt", cnt, 0);

        // Random handshakes against the scoreboard
        sb.delete();
        for (int c = 0; c < 1000; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            #1;
            checkOutput("rand_cnt", cnt, sb.size());
            checkOutput("rand_ir", ir, (sb.size() < 4) || ordy);
            if (ov) begin
                if (sb.size() == 0) checkOutput("rand_ov_empty", ov, 0);
                else                checkOutput("rand_od", od, sb[0]);
            end
            if (ov && ordy && sb.size() > 0) void'(sb.pop_front());
            if (iv && ir) sb.push_back(id);
            step();
        end
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int c = 0; c < 8; c++) begin
            #1;
            checkOutput("tail_cnt", cnt, sb.size());
            if (ov) begin
                if (sb.size() == 0) checkOutput("tail_ov_empty", ov, 0);
                else                checkOutput("tail_od", od, sb.pop_front());
            end
            step();
        end
        checkOutput("tail_final_ov", ov, 0);
        checkOutput("tail_final_cnt", cnt, sb.size());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
